// File: rtl/conv_frame_ctrl_if.sv
// Pixel stream, core strobe and tagged-result signals shared by the frame controller
// and its environment. The controller takes the slave side.
interface conv_frame_ctrl_if #(
    parameter int IMG_W = 34,
    parameter int IMG_H = 34,
    parameter int K     = 3
);
    localparam int ROW_W = $clog2(IMG_H - K + 1);
    localparam int COL_W = $clog2(IMG_W - K + 1);

    logic                    in_valid;
    logic                    in_bit;
    logic                    in_ready;
    logic                    Din_Valid;
    logic                    Din;
    logic                    Cal_Valid;
    logic signed [7:0]       core_dout;
    logic                    out_valid;
    logic signed [7:0]       out_data;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;
    logic                    out_last;

    modport slave (
        input  in_valid, in_bit, core_dout,
        output in_ready, Din_Valid, Din, Cal_Valid,
               out_valid, out_data, out_row, out_col, out_last
    );

    modport master (
        output in_valid, in_bit, core_dout,
        input  in_ready, Din_Valid, Din, Cal_Valid,
               out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the binary 3x3 convolution core: feeds pixels, flushes the last
// window, and tags the core's registered results with coordinates and end-of-frame.
module conv_frame_ctrl #(
    parameter int IMG_W = 34,
    parameter int IMG_H = 34,
    parameter int K     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    conv_frame_ctrl_if.slave      bus,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int PR_W = $clog2(IMG_H);
    localparam int PC_W = $clog2(IMG_W);
    localparam int OR_W = $clog2(IMG_H - K + 1);
    localparam int OC_W = $clog2(IMG_W - K + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t            state_q;
    logic [PR_W-1:0]   pixRow_q, pixRow_d, winRow_q;
    logic [PC_W-1:0]   pixCol_q, pixCol_d, winCol_q;
    logic [OR_W-1:0]   outRow_q, outRow_d;
    logic [OC_W-1:0]   outCol_q, outCol_d;
    logic              winHas_q;
    logic              calValid_q;
    logic              outValid_q;
    logic              drain_q;

    logic              beat;
    logic              winOk;
    logic              lastPix;
    logic              lastOut;

    assign beat    = (state_q == RUN && bus.in_valid) || state_q == FLUSH;
    assign winOk   = winHas_q && winRow_q >= PR_W'(K - 1) && winCol_q >= PC_W'(K - 1);
    assign lastPix = pixRow_q == PR_W'(IMG_H - 1) && pixCol_q == PC_W'(IMG_W - 1);
    assign lastOut = outRow_q == OR_W'(IMG_H - K) && outCol_q == OC_W'(IMG_W - K);

    always_comb begin
        pixCol_d = pixCol_q + PC_W'(1);
        pixRow_d = pixRow_q;
        if (pixCol_q == PC_W'(IMG_W - 1)) begin
            pixCol_d = '0;
            pixRow_d = pixRow_q + PR_W'(1);
        end
        outCol_d = outCol_q + OC_W'(1);
        outRow_d = outRow_q;
        if (outCol_q == OC_W'(IMG_W - K)) begin
            outCol_d = '0;
            outRow_d = outRow_q + OR_W'(1);
        end
    end

    // The core's window on a beat ends at the previously shifted pixel, so the win_*
    // registers trail the pixel counters by one beat and gate Cal_Valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pixRow_q   <= '0;
            pixCol_q   <= '0;
            winRow_q   <= '0;
            winCol_q   <= '0;
            winHas_q   <= 1'b0;
            outRow_q   <= '0;
            outCol_q   <= '0;
            calValid_q <= 1'b0;
            outValid_q <= 1'b0;
            drain_q    <= 1'b0;
        end else if (abort_i) begin
            state_q    <= IDLE;
            pixRow_q   <= '0;
            pixCol_q   <= '0;
            winRow_q   <= '0;
            winCol_q   <= '0;
            winHas_q   <= 1'b0;
            outRow_q   <= '0;
            outCol_q   <= '0;
            calValid_q <= 1'b0;
            outValid_q <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            calValid_q <= beat && winOk;
            outValid_q <= calValid_q;
            if (beat) begin
                winRow_q <= pixRow_q;
                winCol_q <= pixCol_q;
                winHas_q <= (state_q == RUN);
            end
            if (outValid_q) begin
                outRow_q <= outRow_d;
                outCol_q <= outCol_d;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= RUN;
                        pixRow_q <= '0;
                        pixCol_q <= '0;
                        winHas_q <= 1'b0;
                        outRow_q <= '0;
                        outCol_q <= '0;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        pixRow_q <= pixRow_d;
                        pixCol_q <= pixCol_d;
                        if (lastPix) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_q <= DRAIN;
                    drain_q <= 1'b0;
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= IDLE;
                        drain_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.Din_Valid = beat;
    assign bus.Din       = (state_q == RUN) ? bus.in_bit : 1'b0;
    assign bus.Cal_Valid = calValid_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = bus.core_dout;
    assign bus.out_row   = outRow_q;
    assign bus.out_col   = outCol_q;
    assign bus.out_last  = outValid_q && lastOut;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = outValid_q && lastOut;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a behavioural stand-in for the convolution
// core (result = 2 * number of ones in the 3x3 window).
module tb_conv_frame_ctrl;
    localparam int W    = 34;
    localparam int H    = 34;
    localparam int K    = 3;
    localparam int NPIX = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    bit img [0:H-1][0:W-1];

    logic [2*W+2:0]    sr       = '0;
    int                coreSum  = 0;
    logic signed [7:0] coreDout = '0;

    conv_frame_ctrl_if #(.IMG_W(W), .IMG_H(H), .K(K)) bus ();

    conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .abort_i (abort),
        .bus     (bus.slave),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    assign bus.core_dout = coreDout;

    function automatic int winSum(logic [2*W+2:0] s);
        int t = 0;
        for (int i = 0; i < 3; i++)
            t += int'(s[i]) + int'(s[W+i]) + int'(s[2*W+i]);
        return t;
    endfunction

    // Core stand-in: latch the window on each shift beat, register the result on Cal_Valid.
    always @(posedge clk) begin
        if (bus.Din_Valid) begin
            coreSum <= winSum(sr);
            sr      <= {sr[2*W+1:0], bus.Din};
        end
        if (bus.Cal_Valid) coreDout <= 8'(2 * coreSum);
    end

    function automatic logic [7:0] refOut(int r, int c);
        int s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += int'(img[r+i][c+j]);
        return 8'(2 * s);
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(logic v, logic b, logic s, logic a);
        bus.in_valid = v;
        bus.in_bit   = b;
        start        = s;
        abort        = a;
    endtask

    task automatic checkAllLow(string tag);
        checkOutput({tag, "_flags"},
                    {24'd0, busy, done, bus.in_ready, bus.Din_Valid,
                     bus.Cal_Valid, bus.out_valid, bus.out_last, 1'b0}, 32'd0);
        checkOutput({tag, "_coords"}, {22'd0, bus.out_row, bus.out_col}, 32'd0);
    endtask

    // Runs one frame from the start pulse until the first IDLE cycle (observed at its negedge).
    task automatic runFrame(int mode, int gapPct, int abortAt, int startAt, bit timed);
        int  r, p, nOut, expRow, expCol, firstCal, firstOut, lastOut, abortCyc;
        bit  prevBeat, fin, aborted, isLast;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                img[i][j] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        r = 0; p = 0; nOut = 0; expRow = 0; expCol = 0;
        firstCal = -1; firstOut = -1; lastOut = -1; abortCyc = -1;
        prevBeat = 0; fin = 0; aborted = 0;
        while (r < 6000) begin
            bus.in_valid = (p < NPIX) && ($urandom_range(0, 99) >= gapPct);
            bus.in_bit   = (p < NPIX) ? img[p / W][p % W] : 1'b0;
            start        = (r == startAt);
            abort        = (abortAt >= 0) && (p == abortAt) && !aborted;
            if (abort) begin
                aborted  = 1;
                abortCyc = r;
            end
            @(negedge clk);
            if (!prevBeat) checkOutput("calGap", {31'd0, bus.Cal_Valid}, 32'd0);
            if (bus.Cal_Valid && firstCal < 0) firstCal = r;
            if (bus.out_valid) begin
                isLast = (expRow == H - K) && (expCol == W - K);
                if (firstOut < 0) firstOut = r;
                if (isLast) lastOut = r;
                checkOutput("outRow", {27'd0, bus.out_row}, 32'(expRow));
                checkOutput("outCol", {27'd0, bus.out_col}, 32'(expCol));
                checkOutput("outData", {24'd0, bus.out_data}, {24'd0, refOut(expRow, expCol)});
                checkOutput("lastDone", {30'd0, bus.out_last, done}, isLast ? 32'd3 : 32'd0);
                nOut++;
                expCol = (expCol == W - K) ? 0 : expCol + 1;
                if (expCol == 0) expRow++;
            end else begin
                checkOutput("lastIdle", {30'd0, bus.out_last, done}, 32'd0);
            end
            if (bus.in_ready && bus.in_valid) p++;
            prevBeat = bus.Din_Valid;
            if (r > 0 && !busy) begin
                fin = 1;
                break;
            end
            @(posedge clk); #1;
            r++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("frameEnds", {31'd0, fin}, 32'd1);
        if (aborted) begin
            checkOutput("abortIdle", 32'(r), 32'(abortCyc + 1));
            checkOutput("abortReady", {31'd0, bus.in_ready}, 32'd0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                checkOutput("abortQuiet", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
            end
        end else begin
            checkOutput("outCount", 32'(nOut), 32'd1024);
            checkOutput("sawLast", {31'd0, lastOut >= 0}, 32'd1);
            if (timed) begin
                checkOutput("firstCal", 32'(firstCal), 32'd72);
                checkOutput("firstOut", 32'(firstOut), 32'd73);
                checkOutput("lastOut", 32'(lastOut), 32'd1158);
                checkOutput("idleCycle", 32'(r), 32'd1159);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            checkAllLow("reset");
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkAllLow("idleNoStart");
        end

        // start together with abort stays idle.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("startAbort", {30'd0, busy, bus.in_ready}, 32'd0);

        $display("[TB] all-ones frame, continuous input");
        runFrame(0, 0, -1, -1, 1'b1);
        $display("[TB] back-to-back random frame");
        runFrame(2, 0, -1, -1, 1'b1);
        $display("[TB] all-zero frame, 50%% gaps, stray start mid-run");
        runFrame(1, 50, -1, 300, 1'b0);
        $display("[TB] random frame, 30%% gaps");
        runFrame(2, 30, -1, -1, 1'b0);
        $display("[TB] abort at pixel 500");
        runFrame(2, 0, 500, -1, 1'b0);
        $display("[TB] full random frame after abort");
        runFrame(2, 0, -1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
